// File: rtl/a2d_scan_sched.sv
// a2d_scan_sched: sequencer/arbiter in front of A2D_intf (SPI master to ADC128S).
// Round-robin scans channels 0..NUM_CH-1 into a result file and serves one-shot
// requests from a second requester, at most one request between two scan conversions.
//
// Optional feature macro: A2D_TIMEOUT_EN (WAIT timeout, sticky a2d_err).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    scan enable (level)
//   req, req_chnnl        one-shot request pulse and its channel
//   req_busy              request pending or in service (new req ignored)
//   req_done, req_res     one-cycle done pulse, one-shot result (held)
//   strt_cnv, chnnl       conversion start pulse / channel to A2D_intf
//   cnv_cmplt, res        conversion complete / result from A2D_intf
//   rd_chnnl, rd_res      combinational read port of the scan result file
//   scan_done             pulse when the last channel's result is stored
//   a2d_err               sticky timeout flag
module a2d_scan_sched #(
    parameter int NUM_CH  = 8,
    parameter int GAP_CYC = 16,
    parameter int TIMEOUT = 2047
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        req,
    input  logic [2:0]  req_chnnl,
    output logic        req_busy,
    output logic        req_done,
    output logic [11:0] req_res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    input  logic [2:0]  rd_chnnl,
    output logic [11:0] rd_res,
    output logic        scan_done,
    output logic        a2d_err
);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    localparam logic [2:0] LAST  = 3'(NUM_CH - 1);
    localparam logic [7:0] GAP_L = 8'(GAP_CYC);

    state_t      state;
    state_t      nxt;
    logic [2:0]  ptr;
    logic [2:0]  ptr_nx;
    logic [2:0]  scan_ch;
    logic [2:0]  req_ch;
    logic [7:0]  gap_cnt;
    logic [11:0] file [8];
    logic        last_req;
    logic        cur_req;
    logic        go;
    logic        pend_d;
    logic        last_d;
    logic        sel_req;
    logic        sel_scan;
    logic        ok;
    logic        to;
    logic        done;

    assign ok     = (state == WAIT) && cnv_cmplt;
    assign done   = ok || to;
    assign ptr_nx = (ptr == LAST) ? 3'd0 : ptr + 3'd1;

`ifdef A2D_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [TW-1:0] wcnt;

    assign to = (state == WAIT) && !cnv_cmplt && (wcnt == TMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt    <= '0;
            a2d_err <= 1'b0;
        end else begin
            wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
            if (to)
                a2d_err <= 1'b1;
        end
    end
`else
    assign to      = 1'b0;
    assign a2d_err = 1'b0;
`endif

    // Completing in WAIT with no gap decides in the same cycle, so the
    // decision sees the flags as they will be after this completion.
    always_comb begin
        pend_d = req_busy;
        last_d = last_req;
        if (state == WAIT) begin
            pend_d = !cur_req && req_busy;
            last_d = cur_req;
        end
    end

    always_comb begin
        sel_req  = 1'b0;
        sel_scan = 1'b0;
        priority case (1'b1)
            pend_d && (!last_d || !en): sel_req  = 1'b1;
            en:                         sel_scan = 1'b1;
            default: ;
        endcase
    end

    // After a scan store in the no-gap path, the next scan uses the advanced ptr.
    assign scan_ch = (state == WAIT) ? ptr_nx : ptr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    // Next state
    always_comb begin
        nxt = state;
        go  = 1'b0;
        unique case (state)
            IDLE:  go = 1'b1;
            START: nxt = WAIT;
            WAIT: begin
                if (done) begin
                    if (GAP_CYC == 0)
                        go = 1'b1;
                    else
                        nxt = GAP;
                end
            end
            GAP:   go = (gap_cnt == 8'd1);
            default: nxt = IDLE;
        endcase
        if (go)
            nxt = (sel_req || sel_scan) ? START : IDLE;
    end

    // Outputs
    always_comb begin
        strt_cnv = (state == START);
    end

    always_comb begin
        rd_res = 12'h000;
        if (rd_chnnl <= LAST)
            rd_res = file[rd_chnnl];
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 3'd0;
            req_ch    <= 3'd0;
            chnnl     <= 3'd0;
            gap_cnt   <= 8'd0;
            last_req  <= 1'b0;
            cur_req   <= 1'b0;
            req_busy  <= 1'b0;
            req_done  <= 1'b0;
            req_res   <= 12'h000;
            scan_done <= 1'b0;
            for (int i = 0; i < 8; i++)
                file[i] <= 12'h000;
        end else begin
            req_done  <= 1'b0;
            scan_done <= 1'b0;

            // req_done gate drops a request issued in the done cycle.
            if (req && !req_busy && !req_done) begin
                req_busy <= 1'b1;
                req_ch   <= req_chnnl;
            end

            if (go && (sel_req || sel_scan)) begin
                cur_req <= sel_req;
                chnnl   <= sel_req ? req_ch : scan_ch;
            end

            if (done) begin
                gap_cnt <= GAP_L;
                if (cur_req) begin
                    req_res  <= ok ? res : 12'h000;
                    req_done <= 1'b1;
                    req_busy <= 1'b0;
                    last_req <= 1'b1;
                end else begin
                    if (ok)
                        file[ptr] <= res;
                    scan_done <= ok && (ptr == LAST);
                    ptr       <= ptr_nx;
                    last_req  <= 1'b0;
                end
            end else if (state == GAP && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end

            if (state == IDLE && !en)
                ptr <= 3'd0;
        end
    end

endmodule

// File: tb/tb_a2d_scan_sched.sv
// tb_a2d_scan_sched: directed bench for a2d_scan_sched with an ADC model
// (NUM_CH=3, GAP_CYC=4, TIMEOUT=100) and a queue-based scoreboard.
module tb_a2d_scan_sched;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        req;
    logic [2:0]  req_chnnl;
    logic        req_busy;
    logic        req_done;
    logic [11:0] req_res;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [2:0]  rd_chnnl;
    logic [11:0] rd_res;
    logic        scan_done;
    logic        a2d_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_strt = 0;
    int n_rdone = 0;
    int n_sdone = 0;
    int last_cmp = 0;
    bit have_prev = 0;
    bit gap_chk = 0;
    bit adc_hold = 0;
    logic [3:0] epoch = 4'd0;

    logic [2:0]  exp_ch[$];
    logic [11:0] exp_req[$];

    a2d_scan_sched #(
        .NUM_CH(3),
        .GAP_CYC(4),
        .TIMEOUT(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .req(req),
        .req_chnnl(req_chnnl),
        .req_busy(req_busy),
        .req_done(req_done),
        .req_res(req_res),
        .strt_cnv(strt_cnv),
        .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt),
        .res(res),
        .rd_chnnl(rd_chnnl),
        .rd_res(rd_res),
        .scan_done(scan_done),
        .a2d_err(a2d_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] mval(input logic [3:0] ep, input logic [2:0] ch);
        return {ep, 1'b0, ch, 4'h5};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int cnt_of(input int sel);
        case (sel)
            0: return n_strt;
            1: return n_rdone;
            default: return n_sdone;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int target, input int lim, input string nm);
        int k = 0;
        while (cnt_of(sel) < target && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (cnt_of(sel) < target) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout got %0d expected %0d", nm, cnt_of(sel), target);
        end
    endtask

    task automatic pulse(input logic [2:0] c);
        @(posedge clk); #1;
        req = 1'b1;
        req_chnnl = c;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic rd_chk(input logic [2:0] c, input logic [11:0] exp, input string nm);
        @(posedge clk); #1;
        rd_chnnl = c;
        @(negedge clk);
        chk(nm, rd_res, exp);
    endtask

    // ADC model: cnv_cmplt LAT+1 cycles after the strt_cnv cycle
    initial begin
        logic       abusy;
        logic [2:0] ach;
        int         acnt;
        abusy = 1'b0;
        ach = 3'd0;
        acnt = 0;
        cnv_cmplt = 1'b0;
        res = 12'hfff;
        forever begin
            @(negedge clk);
            if (strt_cnv) begin
                abusy = 1'b1;
                ach = chnnl;
                acnt = LAT;
            end
            @(posedge clk); #1;
            cnv_cmplt = 1'b0;
            res = 12'hfff;
            if (!rst_n) begin
                abusy = 1'b0;
            end else if (abusy) begin
                if (acnt != 0) begin
                    acnt--;
                end else if (!adc_hold) begin
                    cnv_cmplt = 1'b1;
                    res = mval(epoch, ach);
                    abusy = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (strt_cnv) begin
                n_strt++;
                if (exp_ch.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL strt_unexpected: got ch %0d expected none", chnnl);
                end else begin
                    chk("strt_ch", chnnl, exp_ch.pop_front());
                end
                if (gap_chk && have_prev)
                    chk("strt_gap", cyc - last_cmp, 5);
            end
            if (req_done) begin
                n_rdone++;
                chk("req_done_busy", req_busy, 0);
                if (exp_req.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL req_done_unexpected: got %0h expected none", req_res);
                end else begin
                    chk("req_res", req_res, exp_req.pop_front());
                end
            end
            if (scan_done)
                n_sdone++;
            if (cnv_cmplt) begin
                last_cmp = cyc;
                have_prev = 1'b1;
            end
        end
    end

    initial begin
        int base;
        int base_r;
        rst_n = 1'b0;
        en = 1'b0;
        req = 1'b0;
        req_chnnl = 3'd0;
        rd_chnnl = 3'd0;
        #3;
        chk("rst_strt", strt_cnv, 0);
        chk("rst_chnnl", chnnl, 0);
        chk("rst_busy", req_busy, 0);
        chk("rst_done", req_done, 0);
        chk("rst_res", req_res, 0);
        chk("rst_sdone", scan_done, 0);
        chk("rst_err", a2d_err, 0);
        chk("rst_rd", rd_res, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: one full scan
        epoch = 4'd1;
        have_prev = 1'b0;
        gap_chk = 1'b1;
        exp_ch.push_back(3'd0);
        exp_ch.push_back(3'd1);
        exp_ch.push_back(3'd2);
        @(posedge clk); #1 en = 1'b1;
        wait_for(2, 1, 100, "t1_scan_done");
        @(posedge clk); #1 en = 1'b0;
        repeat (20) @(negedge clk);
        chk("t1_nstrt", n_strt, 3);
        chk("t1_nsdone", n_sdone, 1);
        rd_chk(3'd0, 12'h105, "t1_rd0");
        rd_chk(3'd1, 12'h115, "t1_rd1");
        rd_chk(3'd2, 12'h125, "t1_rd2");
        rd_chk(3'd3, 12'h000, "t1_rd3");
        rd_chk(3'd5, 12'h000, "t1_rd5");

        // 2: one-shot request while idle
        gap_chk = 1'b0;
        epoch = 4'd2;
        exp_ch.push_back(3'd6);
        exp_req.push_back(12'h265);
        base = n_strt;
        base_r = n_rdone;
        pulse(3'd6);
        @(negedge clk);
        chk("t2_busy", req_busy, 1);
        chk("t2_strt_early", strt_cnv, 0);
        @(negedge clk);
        chk("t2_strt", strt_cnv, 1);
        wait_for(1, base_r + 1, 40, "t2_req_done");
        repeat (15) @(negedge clk);
        chk("t2_nstrt", n_strt, base + 1);
        chk("t2_busy_clr", req_busy, 0);

        // 3+4: request interleaved in scan, en dropped during ch1
        epoch = 4'd3;
        have_prev = 1'b0;
        gap_chk = 1'b1;
        exp_ch.push_back(3'd0);
        exp_ch.push_back(3'd7);
        exp_ch.push_back(3'd1);
        exp_req.push_back(12'h375);
        base = n_strt;
        base_r = n_rdone;
        @(posedge clk); #1 en = 1'b1;
        wait_for(0, base + 1, 20, "t3_ch0");
        pulse(3'd7);
        pulse(3'd4);
        pulse(3'd4);
        wait_for(0, base + 3, 60, "t3_ch1");
        @(posedge clk); #1 en = 1'b0;
        repeat (30) @(negedge clk);
        chk("t4_nstrt", n_strt, base + 3);
        chk("t3_nrdone", n_rdone, base_r + 1);
        rd_chk(3'd0, 12'h305, "t4_rd0");
        rd_chk(3'd1, 12'h315, "t4_rd1");
        rd_chk(3'd2, 12'h125, "t4_rd2");
        gap_chk = 1'b0;
        epoch = 4'd5;
        exp_ch.push_back(3'd0);
        @(posedge clk); #1 en = 1'b1;
        wait_for(0, base + 4, 20, "t4_restart");

        // 5: reset mid-WAIT
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("t5_strt", strt_cnv, 0);
        chk("t5_busy", req_busy, 0);
        chk("t5_res", req_res, 0);
        chk("t5_err", a2d_err, 0);
        chk("t5_rd0", rd_res, 0);
        rd_chnnl = 3'd1;
        #1;
        chk("t5_rd1", rd_res, 0);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rd_chk(3'd2, 12'h000, "t5_rd2");
        epoch = 4'd6;
        base = n_strt;
        exp_ch.push_back(3'd0);
        @(posedge clk); #1 en = 1'b1;
        wait_for(0, base + 1, 20, "t5_ch0");
        @(posedge clk); #1 en = 1'b0;
        repeat (20) @(negedge clk);
        rd_chk(3'd0, 12'h605, "t5_rd0_new");
        rd_chk(3'd1, 12'h000, "t5_rd1_new");
        chk("t5_nstrt", n_strt, base + 1);

        // 6: ADC never completes
        adc_hold = 1'b1;
        base = n_strt;
        base_r = n_rdone;
        exp_ch.push_back(3'd2);
`ifdef A2D_TIMEOUT_EN
        exp_req.push_back(12'h000);
        pulse(3'd2);
        wait_for(1, base_r + 1, 150, "t6_req_done");
        chk("t6_err", a2d_err, 1);
        repeat (10) @(negedge clk);
        chk("t6_err_sticky", a2d_err, 1);
`else
        pulse(3'd2);
        repeat (150) @(negedge clk);
        chk("t6_no_done", n_rdone, base_r);
        chk("t6_err", a2d_err, 0);
        chk("t6_busy", req_busy, 1);
`endif
        chk("t6_nstrt", n_strt, base + 1);
        chk("end_exp_ch", exp_ch.size(), 0);
        chk("end_exp_req", exp_req.size(), 0);
        chk("end_nsdone", n_sdone, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
